// File: rtl/frame_prefetch.sv
// rtl/frame_prefetch.sv - framebuffer request/prefetch FIFO feeding VGA scan-out.
// Issues paced pixel requests, captures returns after a fixed latency, re-aligns every frame.
module frame_prefetch #(
  parameter int DEPTH        = 4,
  parameter int PIXEL_W      = 4,
  parameter int RD_LATENCY   = 2,
  parameter int REQ_GAP      = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       pix_pop,
  output logic                       pix_valid,
  output logic [PIXEL_W-1:0]         pix_data,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_next_pixel_out,
  output logic                       frame_reset_out,
  input  logic [PIXEL_W-1:0]         frame_pixel_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = ($clog2(REQ_GAP) > 0) ? $clog2(REQ_GAP) : 1;
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int CW = $clog2(DEPTH + RD_LATENCY + 1) + 1;

  typedef enum logic {S_HOLD, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    underflow_q, underflow_d;
  logic                    valid_q, valid_d;
  logic                    req_q, req_d;
  logic                    rst_out_q, rst_out_d;
  logic [PIXEL_W-1:0]      mem_q [DEPTH];

  logic                    push, pop, wr_en;
  logic [CW-1:0]           occ;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    pipe_d      = pipe_q << 1;
    pipe_d[0]   = req_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;
    push        = pipe_q[RD_LATENCY-1];
    pop         = pix_pop && (level_q != '0);
    wr_en       = push && !frame_start;

    // gap_q holds the number of cycles still blocked after the last request
    if (req_q)
      gap_d = GW'(REQ_GAP - 1);
    else if (gap_q != '0)
      gap_d = gap_q - GW'(1);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
    if (pix_pop && (level_q == '0))
      underflow_d = 1'b1;

    // the hold count only advances while frame_reset_out is actually driven high
    if (state_q == S_HOLD) begin
      if (rst_out_q && (hold_q == HW'(RESET_CYCLES - 1))) begin
        state_d = S_RUN;
        hold_d  = '0;
      end else if (rst_out_q) begin
        hold_d = hold_q + HW'(1);
      end
    end

    if (frame_start) begin
      state_d     = S_HOLD;
      hold_d      = '0;
      gap_d       = '0;
      pipe_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
    end

    occ = CW'(level_d);
    for (int i = 0; i < RD_LATENCY; i++)
      occ = occ + CW'(pipe_d[i]);

    req_d     = (state_d == S_RUN) && (gap_d == '0) && (occ < CW'(DEPTH));
    rst_out_d = (state_d == S_HOLD);
    valid_d   = (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      gap_q       <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      rst_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      rst_out_q   <= rst_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem_q[wr_ptr_q] <= frame_pixel_in;
  end

  assign pix_valid            = valid_q;
  assign pix_data             = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign underflow            = underflow_q;
  assign level                = level_q;
  assign frame_next_pixel_out = req_q;
  assign frame_reset_out      = rst_out_q;

endmodule

// File: tb/tb_frame_prefetch.sv
// tb/tb_frame_prefetch.sv - directed bench for frame_prefetch with a latency-2 framebuffer model.
module tb_frame_prefetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_pop = 1'b0;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       underflow;
  logic [2:0] level;
  logic       frame_next_pixel_out;
  logic       frame_reset_out;
  logic [3:0] frame_pixel_in;

  int n_assert = 0;
  int n_fail   = 0;
  int req_cnt;

  logic [3:0] fb_d1 = 4'h5;
  logic [3:0] fb_d2 = 4'h5;
  logic [3:0] fb_ptr = 4'h0;
  logic [3:0] exp_data [8];
  int         lvl_tab [6];
  int         req_tab [6];

  frame_prefetch dut (
    .clk                  (clk),
    .rst                  (rst),
    .frame_start          (frame_start),
    .pix_pop              (pix_pop),
    .pix_valid            (pix_valid),
    .pix_data             (pix_data),
    .underflow            (underflow),
    .level                (level),
    .frame_next_pixel_out (frame_next_pixel_out),
    .frame_reset_out      (frame_reset_out),
    .frame_pixel_in       (frame_pixel_in)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input logic [3:0] i);
    case (i)
      4'd0: pat = 4'h3;
      4'd1: pat = 4'h7;
      4'd2: pat = 4'hA;
      4'd3: pat = 4'hF;
      4'd4: pat = 4'h1;
      4'd5: pat = 4'h2;
      4'd6: pat = 4'h4;
      4'd7: pat = 4'h6;
      default: pat = 4'h8;
    endcase
  endfunction

  // Framebuffer: pointer reset by frame_reset_out, pixel visible two cycles after the request, junk 5 otherwise
  always @(posedge clk) begin
    fb_d1 <= frame_next_pixel_out ? pat(fb_ptr) : 4'h5;
    fb_d2 <= fb_d1;
    if (frame_reset_out)
      fb_ptr <= 4'h0;
    else if (frame_next_pixel_out)
      fb_ptr <= fb_ptr + 4'h1;
  end
  assign frame_pixel_in = fb_d2;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge following a reset edge; releases rst and checks the power-up sequence
  task automatic release_seq(input string pfx);
    int exp_lvl;
    chk({pfx, "_rst_fro"}, 32'(frame_reset_out), 32'd0);
    chk({pfx, "_rst_req"}, 32'(frame_next_pixel_out), 32'd0);
    chk({pfx, "_rst_lvl"}, 32'(level), 32'd0);
    chk({pfx, "_rst_valid"}, 32'(pix_valid), 32'd0);
    chk({pfx, "_rst_uf"}, 32'(underflow), 32'd0);
    chk({pfx, "_rst_data"}, 32'(pix_data), 32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp_lvl = (c < 8) ? 0 : (c < 10) ? 1 : (c < 12) ? 2 : (c < 14) ? 3 : 4;
      chk($sformatf("%s_fro_c%0d", pfx, c), 32'(frame_reset_out), 32'((c >= 1) && (c <= 4)));
      chk($sformatf("%s_req_c%0d", pfx, c), 32'(frame_next_pixel_out),
          32'((c == 5) || (c == 7) || (c == 9) || (c == 11)));
      chk($sformatf("%s_lvl_c%0d", pfx, c), 32'(level), 32'(exp_lvl));
    end
  endtask

  initial begin
    exp_data = '{4'h3, 4'h7, 4'hA, 4'hF, 4'h1, 4'h2, 4'h4, 4'h6};
    lvl_tab  = '{0, 0, 0, 1, 1, 2};
    req_tab  = '{1, 0, 1, 0, 1, 0};

    repeat (3) tick();
    release_seq("rel1");

    // Data ordering with a pop every second cycle, starting from a full FIFO
    req_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (frame_next_pixel_out) req_cnt++;
      chk($sformatf("ord_lvlmax_k%0d", k), 32'(level <= 3'd4), 32'd1);
      if ((k % 2) == 0) begin
        chk($sformatf("ord_data_%0d", k / 2), 32'(pix_data), 32'(exp_data[k / 2]));
        chk($sformatf("ord_valid_%0d", k / 2), 32'(pix_valid), 32'd1);
        pix_pop = 1'b1;
      end else begin
        pix_pop = 1'b0;
      end
      tick();
    end
    chk("ord_req_count", 32'(req_cnt), 32'd8);

    // Underflow: pop while empty in the first HOLD cycle
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("uf_flush_lvl", 32'(level), 32'd0);
    chk("uf_flush_uf", 32'(underflow), 32'd0);
    pix_pop = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("uf_fro_c%0d", c), 32'(frame_reset_out), 32'd1);
      chk($sformatf("uf_req_c%0d", c), 32'(frame_next_pixel_out), 32'd0);
      tick();
      pix_pop = 1'b0;
      if (c == 1) begin
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_data", 32'(pix_data), 32'd0);
        chk("uf_lvl", 32'(level), 32'd0);
        chk("uf_valid", 32'(pix_valid), 32'd0);
      end
    end
    chk("uf_run_fro", 32'(frame_reset_out), 32'd0);
    chk("uf_run_req", 32'(frame_next_pixel_out), 32'd1);

    // Mid-flight frame_start one cycle after a request
    tick();
    chk("mid_uf_sticky", 32'(underflow), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("mid_uf_clr", 32'(underflow), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("mid_fro_c%0d", c), 32'(frame_reset_out), 32'd1);
      chk($sformatf("mid_req_c%0d", c), 32'(frame_next_pixel_out), 32'd0);
      chk($sformatf("mid_lvl_c%0d", c), 32'(level), 32'd0);
      tick();
    end
    chk("mid_resume_fro", 32'(frame_reset_out), 32'd0);
    chk("mid_resume_req", 32'(frame_next_pixel_out), 32'd1);
    chk("mid_resume_lvl", 32'(level), 32'd0);

    // Simultaneous push and pop at level 2, then fill to 4
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("pp_lvl_s%0d", c), 32'(level), 32'(lvl_tab[c]));
      chk($sformatf("pp_req_s%0d", c), 32'(frame_next_pixel_out), 32'(req_tab[c]));
    end
    tick();
    chk("pp_pre_lvl", 32'(level), 32'd2);
    chk("pp_pre_req", 32'(frame_next_pixel_out), 32'd1);
    chk("pp_pre_head", 32'(pix_data), 32'h3);
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    chk("pp_post_lvl", 32'(level), 32'd2);
    chk("pp_post_head", 32'(pix_data), 32'h7);
    chk("pp_post_req", 32'(frame_next_pixel_out), 32'd0);
    tick();
    chk("pp_s8_lvl", 32'(level), 32'd2);
    chk("pp_s8_req", 32'(frame_next_pixel_out), 32'd1);
    for (int c = 9; c <= 14; c++) begin
      tick();
      chk($sformatf("pp_lvl_s%0d", c), 32'(level), (c < 11) ? 32'd3 : 32'd4);
      chk($sformatf("pp_req_s%0d", c), 32'(frame_next_pixel_out), 32'd0);
    end
    chk("pp_full_head", 32'(pix_data), 32'h7);

    // Reset with level 3 and one request in flight
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    chk("rm_pre_lvl", 32'(level), 32'd3);
    chk("rm_pre_req", 32'(frame_next_pixel_out), 32'd1);
    tick();
    chk("rm_inflight_lvl", 32'(level), 32'd3);
    rst = 1'b1;
    tick();
    release_seq("rel2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
